// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
// Shared types and constants for the instruction fetch stage.
//   fetch_state_t : sequencer states (IDLE, RUN)
//   OP_JUMP       : opcode [31:26] of an unconditional jump word
//   BASE_*        : program base addresses in the instruction memory
//   DEF_PC_W / DEF_INSTR_W : default PC and instruction widths
//   base_addr()   : program_sel -> base address (select 3 is reserved -> 0)
// ---------------------------------------------------------------------------
package fetch_pkg;

    localparam int DEF_PC_W    = 10;
    localparam int DEF_INSTR_W = 32;

    localparam logic [5:0] OP_JUMP = 6'b010000;

    localparam int unsigned BASE_FIB   = 0;
    localparam int unsigned BASE_FACT  = 15;
    localparam int unsigned BASE_SYNTH = 25;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } fetch_state_t;

    function automatic int unsigned base_addr(input logic [1:0] sel);
        case (sel)
            2'd1:    return BASE_FACT;
            2'd2:    return BASE_SYNTH;
            default: return BASE_FIB;
        endcase
    endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// ---------------------------------------------------------------------------
// fetch_skid_buffer
// One-entry holding register for a fetched word {instr, pc}. It catches the
// word returned by the memory when the output register is still occupied,
// because the memory re-reads every edge and would otherwise lose it.
//   i_clock, i_reset_n : clock, async active-low reset
//   i_flush            : empty the entry (highest priority)
//   i_load             : store {i_instr, i_pc} and mark valid
//   i_drain            : entry has been moved to the output; mark empty
//   o_valid, o_instr, o_pc : current entry
// ---------------------------------------------------------------------------
module fetch_skid_buffer #(
    parameter int PC_W    = 10,
    parameter int INSTR_W = 32
) (
    input  logic               i_clock,
    input  logic               i_reset_n,
    input  logic               i_flush,
    input  logic               i_load,
    input  logic               i_drain,
    input  logic [INSTR_W-1:0] i_instr,
    input  logic [PC_W-1:0]    i_pc,
    output logic               o_valid,
    output logic [INSTR_W-1:0] o_instr,
    output logic [PC_W-1:0]    o_pc
);

    logic               r_valid;
    logic [INSTR_W-1:0] r_instr;
    logic [PC_W-1:0]    r_pc;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_valid <= 1'b0;
            r_instr <= '0;
            r_pc    <= '0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_instr <= i_instr;
            r_pc    <= i_pc;
        end else if (i_drain) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_instr = r_instr;
    assign o_pc    = r_pc;

endmodule

// File: rtl/instruction_fetch.sv
// ---------------------------------------------------------------------------
// instruction_fetch
// PC sequencer in front of a synchronous instruction memory (registered read,
// no enable). Issues one address per cycle, tags the word that returns one
// clock later with its PC and hands it to decode over valid/ready.
//
// Optional feature macro: FETCH_EARLY_JUMP_EN
//   defined   - jump words (opcode OP_JUMP) are consumed here: pc takes
//               instr[PC_W-1:0] and the word is never presented downstream.
//   undefined - jump words are forwarded like any other word.
//
// Ports
//   clock, reset_n        : clock shared with the memory, async active-low reset
//   start, program_sel    : begin (or restart) the selected program
//   stop                  : return to IDLE, flush everything, pc = 0
//   redirect_valid/addr   : branch/jump target from execute
//   address               : memory address, always the pc register
//   instrucao             : memory read data (for the address of the last edge)
//   instr_out/pc/valid    : word to decode; instr_ready accepts it
//   running               : high in RUN
//
// State | meaning
// ------+-------------------------------------------------------------
// IDLE  | pc held at 0, nothing issued, output and skid empty
// RUN   | issuing sequential addresses, capturing returned words
// ---------------------------------------------------------------------------
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter int PC_W    = DEF_PC_W,
    parameter int INSTR_W = DEF_INSTR_W
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               start,
    input  logic               stop,
    input  logic [1:0]         program_sel,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_addr,
    output logic [PC_W-1:0]    address,
    input  logic [INSTR_W-1:0] instrucao,
    output logic [INSTR_W-1:0] instr_out,
    output logic [PC_W-1:0]    instr_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic               running
);

    fetch_state_t       r_state;
    logic [PC_W-1:0]    r_pc;
    logic               r_f1_valid;
    logic [PC_W-1:0]    r_f1_pc;
    logic [INSTR_W-1:0] r_instr_out;
    logic [PC_W-1:0]    r_instr_pc;
    logic               r_instr_valid;

    logic               w_skid_valid;
    logic [INSTR_W-1:0] w_skid_instr;
    logic [PC_W-1:0]    w_skid_pc;

    logic w_accept;
    logic w_out_free;
    logic w_redirect;
    logic w_flush;
    logic w_jump;
    logic w_capture;
    logic w_issue;
    logic w_skid_load;
    logic w_skid_drain;

    // Output slot is free this edge if empty or being accepted right now.
    assign w_accept   = r_instr_valid && instr_ready;
    assign w_out_free = !r_instr_valid || instr_ready;

    // Redirects only mean something while a program is running.
    assign w_redirect = (r_state == ST_RUN) && redirect_valid;
    assign w_flush    = stop || w_redirect || start;

`ifdef FETCH_EARLY_JUMP_EN
    assign w_jump = r_f1_valid && (instrucao[INSTR_W-1 -: 6] == OP_JUMP);
`else
    assign w_jump = 1'b0;
`endif

    // The returning word must be taken this edge; the memory overwrites it next.
    assign w_capture = r_f1_valid && !w_jump;

    // Issue only when the word we would fetch is guaranteed a landing place:
    // skid empty and output free. A jump being consumed squashes this issue.
    assign w_issue = (r_state == ST_RUN) && !w_skid_valid && w_out_free && !w_jump;

    // Skid and in-flight word are never both valid (issue needs an empty skid),
    // so drain and load cannot collide.
    assign w_skid_drain = !w_flush && (r_state == ST_RUN) && w_skid_valid && w_out_free;
    assign w_skid_load  = !w_flush && (r_state == ST_RUN) && w_capture && !w_out_free;

    fetch_skid_buffer #(
        .PC_W    (PC_W),
        .INSTR_W (INSTR_W)
    ) u_skid (
        .i_clock   (clock),
        .i_reset_n (reset_n),
        .i_flush   (w_flush),
        .i_load    (w_skid_load),
        .i_drain   (w_skid_drain),
        .i_instr   (instrucao),
        .i_pc      (r_f1_pc),
        .o_valid   (w_skid_valid),
        .o_instr   (w_skid_instr),
        .o_pc      (w_skid_pc)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_IDLE;
            r_pc          <= '0;
            r_f1_valid    <= 1'b0;
            r_f1_pc       <= '0;
            r_instr_out   <= '0;
            r_instr_pc    <= '0;
            r_instr_valid <= 1'b0;
        end else if (stop) begin
            r_state       <= ST_IDLE;
            r_pc          <= '0;
            r_f1_valid    <= 1'b0;
            r_instr_valid <= 1'b0;
        end else if (w_redirect) begin
            r_pc          <= redirect_addr;
            r_f1_valid    <= 1'b0;
            r_instr_valid <= 1'b0;
        end else if (start) begin
            // From IDLE this is the program launch; in RUN it is a restart,
            // i.e. a redirect to the program base.
            r_state       <= ST_RUN;
            r_pc          <= PC_W'(base_addr(program_sel));
            r_f1_valid    <= 1'b0;
            r_instr_valid <= 1'b0;
        end else if (r_state == ST_RUN) begin
            r_f1_valid <= w_issue;
            if (w_jump) begin
                r_pc <= instrucao[PC_W-1:0];
            end else if (w_issue) begin
                r_f1_pc <= r_pc;
                r_pc    <= r_pc + PC_W'(1);
            end

            // Skid drains before any new memory word reaches the output.
            if (w_skid_drain) begin
                r_instr_out   <= w_skid_instr;
                r_instr_pc    <= w_skid_pc;
                r_instr_valid <= 1'b1;
            end else if (w_capture && w_out_free) begin
                r_instr_out   <= instrucao;
                r_instr_pc    <= r_f1_pc;
                r_instr_valid <= 1'b1;
            end else if (w_accept) begin
                r_instr_valid <= 1'b0;
            end
        end
    end

    assign address     = r_pc;
    assign instr_out   = r_instr_out;
    assign instr_pc    = r_instr_pc;
    assign instr_valid = r_instr_valid;
    assign running     = (r_state == ST_RUN);

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

    logic        clock;
    logic        reset_n;
    logic        start;
    logic        stop;
    logic [1:0]  program_sel;
    logic        redirect_valid;
    logic [9:0]  redirect_addr;
    logic [9:0]  address;
    logic [31:0] instrucao;
    logic [31:0] instr_out;
    logic [9:0]  instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        running;

    instruction_fetch dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .start          (start),
        .stop           (stop),
        .program_sel    (program_sel),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .address        (address),
        .instrucao      (instrucao),
        .instr_out      (instr_out),
        .instr_pc       (instr_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .running        (running)
    );

    int errors = 0;
    int checks = 0;
    int acc_cnt = 0;
    int ready_mode = 1;      // 0 random, 1 high, 2 low
    logic exp_running = 1'b0;

    logic [31:0] mem [0:1023];

    typedef struct {
        logic [9:0]  pc;
        logic [31:0] w;
    } exp_t;
    exp_t expq[$];

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Synchronous-read instruction memory: word for the sampled address
    // appears after the edge.
    always @(posedge clock) instrucao <= mem[address];

    initial begin
        instr_ready = 1'b0;
        forever begin
            @(posedge clock);
            #2;
            case (ready_mode)
                0:       instr_ready = ($urandom_range(0, 99) < 60);
                1:       instr_ready = 1'b1;
                default: instr_ready = 1'b0;
            endcase
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Reference: the stream decode should see after the fetch is pointed at
    // start_pc. Sequential PCs modulo 1024; with early jumps, jump words are
    // swallowed and the stream continues at their target.
    task automatic load_seq(input logic [9:0] start_pc);
        logic [9:0] pc;
        int n;
        int guard;
        pc = start_pc;
        n = 0;
        guard = 0;
        expq.delete();
        while (n < 300 && guard < 2000) begin
            guard++;
`ifdef FETCH_EARLY_JUMP_EN
            if (mem[pc][31:26] == 6'b010000) begin
                pc = mem[pc][9:0];
                continue;
            end
`endif
            expq.push_back('{pc, mem[pc]});
            pc = pc + 10'd1;
            n++;
        end
    endtask

    function automatic logic [9:0] base_of(input logic [1:0] sel);
        if (sel == 2'd1) return 10'd15;
        if (sel == 2'd2) return 10'd25;
        return 10'd0;
    endfunction

    // Monitor / scoreboard: everything is sampled on the falling edge, so it
    // describes what the next rising edge will do.
    initial begin : monitor
        logic        p_stall;
        logic [31:0] p_out;
        logic [9:0]  p_pc;
        exp_t        e;
        p_stall = 1'b0;
        p_out = '0;
        p_pc = '0;
        forever begin
            @(negedge clock);
            if (reset_n === 1'b1) begin
                chk("running", 32'(running), 32'(exp_running));
                if (p_stall) begin
                    chk("hold_valid", 32'(instr_valid), 32'd1);
                    chk("hold_word", instr_out, p_out);
                    chk("hold_pc", 32'(instr_pc), 32'(p_pc));
                end
                if (instr_valid && instr_ready) begin
                    acc_cnt++;
                    if (expq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL seq_empty: got pc %0d word %h expected no word", instr_pc, instr_out);
                    end else begin
                        e = expq.pop_front();
                        chk("seq_pc", 32'(instr_pc), 32'(e.pc));
                        chk("seq_word", instr_out, e.w);
                    end
                end
            end
            p_stall = (reset_n === 1'b1) && instr_valid && !instr_ready
                      && !stop && !redirect_valid && !start;
            p_out = instr_out;
            p_pc = instr_pc;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_acc(input int n, input int budget);
        int target;
        int cyc;
        target = acc_cnt + n;
        cyc = 0;
        while (acc_cnt < target && cyc < budget) begin
            tick();
            cyc++;
        end
        checks++;
        if (acc_cnt < target) begin
            errors++;
            $display("FAIL progress_timeout: got %0d accepts expected %0d", acc_cnt, target);
        end
    endtask

    task automatic do_start(input logic [1:0] sel);
        program_sel = sel;
        start = 1'b1;
        tick();
        start = 1'b0;
        load_seq(base_of(sel));
        exp_running = 1'b1;
        chk("start_addr", 32'(address), 32'(base_of(sel)));
    endtask

    task automatic do_redirect(input logic [9:0] a);
        redirect_addr = a;
        redirect_valid = 1'b1;
        tick();
        redirect_valid = 1'b0;
        load_seq(a);
        chk("redir_addr", 32'(address), 32'(a));
    endtask

    task automatic do_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        expq.delete();
        exp_running = 1'b0;
        chk("stop_addr", 32'(address), 32'd0);
        chk("stop_valid", 32'(instr_valid), 32'd0);
    endtask

    initial begin : stim
        logic [31:0] w;
        logic [31:0] h_out;
        logic [9:0]  h_pc;
        logic [9:0]  a;

        for (int i = 0; i < 1024; i++) begin
            w = $urandom;
            if (w[31:26] == 6'b010000) w[31] = 1'b1;
            mem[i] = w;
        end
        mem[0]  = 32'hA81E0000;
        mem[15] = 32'hA81E0000;
        mem[7]  = 32'h1002003D;
        mem[9]  = 32'h03E10802;
        mem[10] = 32'h40000007;

        reset_n = 1'b0;
        start = 1'b0;
        stop = 1'b0;
        program_sel = 2'd0;
        redirect_valid = 1'b0;
        redirect_addr = '0;
        #1;
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_addr", 32'(address), 32'd0);
        chk("rst_running", 32'(running), 32'd0);
        chk("rst_pc", 32'(instr_pc), 32'd0);
        chk("rst_out", instr_out, 32'd0);
        repeat (3) tick();
        reset_n = 1'b1;
        repeat (2) tick();
        chk("idle_addr", 32'(address), 32'd0);
        chk("idle_valid", 32'(instr_valid), 32'd0);

        // Fibonacci launch and latency
        ready_mode = 1;
        tick();
        do_start(2'd0);
        chk("lat_e0_valid", 32'(instr_valid), 32'd0);
        tick();
        chk("lat_e1_valid", 32'(instr_valid), 32'd0);
        chk("lat_e1_addr", 32'(address), 32'd1);
        tick();
        chk("lat_e2_valid", 32'(instr_valid), 32'd1);
        chk("lat_e2_pc", 32'(instr_pc), 32'd0);
        chk("lat_e2_word", instr_out, 32'hA81E0000);
        wait_acc(25, 200);

        // Back-pressure for 5 cycles mid-stream
        ready_mode = 2;
        tick();
        tick();
        h_out = instr_out;
        h_pc = instr_pc;
        chk("stall_valid", 32'(instr_valid), 32'd1);
        repeat (5) tick();
        chk("stall_word", instr_out, h_out);
        chk("stall_pc", 32'(instr_pc), 32'(h_pc));
        ready_mode = 1;
        wait_acc(10, 100);

        // Redirect to 7 with words in flight
        do_redirect(10'd7);
        tick();
        tick();
        chk("redir_valid", 32'(instr_valid), 32'd1);
        chk("redir_pc", 32'(instr_pc), 32'd7);
        chk("redir_word", instr_out, 32'h1002003D);
        wait_acc(8, 100);

        // Restart as factorial while running
        do_start(2'd1);
        tick();
        tick();
        chk("fact_valid", 32'(instr_valid), 32'd1);
        chk("fact_pc", 32'(instr_pc), 32'd15);
        chk("fact_word", instr_out, 32'hA81E0000);
        wait_acc(5, 100);

        // PC wrap 1023 -> 0
        do_redirect(10'd1021);
        wait_acc(6, 100);

        // Randomised control traffic with random back-pressure
        ready_mode = 0;
        for (int k = 0; k < 16; k++) begin
            repeat ($urandom_range(3, 20)) tick();
            case ($urandom_range(0, 3))
                0: begin
                    a = ($urandom_range(0, 2) == 0) ? 10'(1018 + $urandom_range(0, 5))
                                                     : 10'($urandom_range(0, 1023));
                    do_redirect(a);
                    wait_acc(3, 150);
                end
                1: begin
                    do_start(2'($urandom_range(0, 3)));
                    wait_acc(3, 150);
                end
                2: begin
                    do_stop();
                    repeat ($urandom_range(1, 4)) tick();
                    do_start(2'($urandom_range(0, 3)));
                    wait_acc(3, 150);
                end
                default: begin
                    do_redirect(10'd7);
                    wait_acc(4, 150);
                end
            endcase
        end

        // Asynchronous reset mid-stream
        ready_mode = 1;
        wait_acc(3, 100);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_valid", 32'(instr_valid), 32'd0);
        chk("arst_addr", 32'(address), 32'd0);
        chk("arst_running", 32'(running), 32'd0);
        expq.delete();
        exp_running = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();

        // Synthetic program, then stop
        do_start(2'd2);
        wait_acc(6, 100);
        do_stop();
        repeat (5) tick();
        chk("final_valid", 32'(instr_valid), 32'd0);
        chk("final_addr", 32'(address), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Program-counter and fetch-sequencing stage directly upstream of `Instructions_memory`. Drives the memory's 10-bit `address`, tags the 32-bit word returned one clock later with its PC, and presents it to decode over a valid/ready handshake. Handles program selection and start, redirects from execute, and back-pressure via a one-entry skid buffer. The memory has no enable and re-reads every edge, so this block also handles word capture during back-pressure.

## Interface
- `PC_W`, default 10: PC/address width, matching the memory address.
- `INSTR_W`, default 32: instruction width.
- `clock`  in  1  rising-edge clock shared with `Instructions_memory`.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse that begins the program chosen by `program_sel`.
- `stop`  in  1  pulse that returns the block to IDLE and flushes it.
- `program_sel`  in  2  0 selects fibonacci at base 0; 1 selects factorial at base 15; 2 selects synthetic at base 25; 3 is reserved and maps to 0.
- `redirect_valid`  in  1  branch or jump resolved in execute.
- `redirect_addr`  in  PC_W  redirect target.
- `address`  out  PC_W  to memory `address`; always equals the `pc` register.
- `instrucao`  in  INSTR_W  from the memory, valid the cycle after the address is sampled.
- `instr_out`  out  INSTR_W  instruction to decode.
- `instr_pc`  out  PC_W  PC of `instr_out`.
- `instr_valid`  out  1  `instr_out` holds a live word.
- `instr_ready`  in  1  decode accepts when `instr_valid && instr_ready` at an edge.
- `running`  out  1  high in RUN.

## Operation
- States and transitions:
  - IDLE to RUN on `start`; `pc` is loaded with the base address.
  - RUN to IDLE on `stop`; all stages are flushed and `pc` is set to 0.
  - `start` in RUN restarts the program, behaving as a redirect to the base address.
- Event priority, highest first: `stop`, then `redirect_valid`, then `start`, then normal issue.
- Issue rule:
  - Issue happens in RUN when the skid buffer is empty and (`!instr_valid || instr_ready`).
  - An issue sets in-flight flag `f1_valid` and `f1_pc` = `pc` for the next cycle, and advances `pc` by 1.
  - Arithmetic is modulo 2^PC_W, so 1023 wraps to 0.
- Capture, in order of destination:
  - An in-flight word (`f1_valid`) goes to the output register when the output is free, or to the skid buffer otherwise.
  - The skid buffer drains to the output before any new memory word.
- Redirect:
  - Clears `f1_valid`, the skid buffer and `instr_valid`, and sets `pc` = `redirect_addr`.
  - A word accepted in the same edge is still considered accepted.
- In IDLE, `pc` = 0, so `address` = 0. This guarantees the memory's address-0 initialisation edge before any program runs.

## Timing
- Reset values:
  - State IDLE.
  - `pc`, `address`, `instr_pc` = 0; `instr_out` = 0.
  - `instr_valid`, `running`, `f1_valid` = 0; skid buffer empty.
- Latency:
  - `start` at edge 0 loads `pc`.
  - The memory samples `pc` at edge 1.
  - `instr_valid` goes high after edge 2.
  - Redirect-to-valid is likewise 2 edges.
- Throughput: one word per cycle while `instr_ready` is held high.
- At most one word is in flight, and the skid buffer never overflows.
- A reset assertion mid-run returns all state to reset values immediately.

## Configuration
- `FETCH_EARLY_JUMP_EN`:
  - Defined: a captured word with opcode `[31:26]` = 6'b010000 is consumed in fetch and never presented downstream. `pc` = `instr[9:0]`, and the in-flight sequential word is squashed (one bubble). An external redirect in the same cycle wins.
  - Undefined: jump words are forwarded like any other word, and execute must redirect.

## Structure
- Package `fetch_pkg` holds:
  - the state enum (IDLE, RUN);
  - `OP_JUMP` = 6'b010000;
  - `BASE_FIB` = 0, `BASE_FACT` = 15, `BASE_SYNTH` = 25;
  - the `PC_W`/`INSTR_W` defaults.
- Sub-module `fetch_skid_buffer` holds one entry {`instr`, `pc`} with load, drain and flush controls.

## Test plan
- Reset, then `program_sel`=0 with a `start` pulse and `instr_ready`=1 → after edge 2 `instr_valid`=1, `instr_pc`=0, `instr_out`=0xA81E0000. Following words appear at PC 1, 2, … consecutively.
- `program_sel`=1 with `start` → first valid word has `instr_pc`=15 and `instr_out`=0xA81E0000.
- Hold `instr_ready`=0 for 5 cycles mid-stream → `instr_out`/`instr_pc` stay stable and no PC is skipped or duplicated after release.
- `redirect_valid` with `redirect_addr`=7 while words are in flight → the next valid word has `instr_pc`=7 and `instr_out`=0x1002003D.
- With `FETCH_EARLY_JUMP_EN`, fibonacci run → the word at PC 9 (0x03E10802) is followed by PC 7. The jump word 0x40000007 is never valid downstream. Without the macro, PC 10 is presented.
- `pc` at 1023 → the next issue uses address 0. Assert `reset_n`=0 mid-stream → `instr_valid`=0 immediately and `address`=0.
